serdes_framed: RTL and testbench



---
 rtl/serdes_pkg.sv | 29 ++
 rtl/serdes_rx_deframer.sv | 114 +++++++++++
 rtl/serdes_framed.sv | 111 +++++++++++
 tb/tb_serdes_framed.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types and line constants for the framed serdes.
// Optional parity support is selected with SERDES_FRAMED_PARITY_EN in the RTL files.
package serdes_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Width of a counter that indexes DATA_W payload bits.
    function automatic int cnt_w(input int data_w);
        return (data_w < 2) ? 1 : $clog2(data_w);
    endfunction

endpackage

// File: rtl/serdes_rx_deframer.sv
// RX path: ser_in synchroniser, frame FSM, payload shift register and error flags.
// Parity checking is compiled in with SERDES_FRAMED_PARITY_EN.
module serdes_rx_deframer #(
    parameter int DATA_W      = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_line,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_parity_err
);
    import serdes_pkg::*;

    localparam int            CW   = cnt_w(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic ser_s;

    // Synchroniser resets to the idle level so reset release never looks like a start bit.
    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign ser_s = ser_line;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '1;
                end else begin
                    sync_q[0] <= ser_line;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign ser_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    rx_state_e         state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shift;
    logic              in_data, in_stop;

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            RX_IDLE: if (ser_s == START_BIT) state_nxt = RX_DATA;
`ifdef SERDES_FRAMED_PARITY_EN
            RX_DATA: if (cnt == LAST) state_nxt = RX_PAR;
`else
            RX_DATA: if (cnt == LAST) state_nxt = RX_STOP;
`endif
            RX_PAR:  state_nxt = RX_STOP;
            RX_STOP: state_nxt = RX_IDLE;
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        in_data = (state == RX_DATA);
        in_stop = (state == RX_STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (in_data) begin
                cnt <= cnt + CW'(1);
                if (MSB_FIRST) shift <= {shift[DATA_W-2:0], ser_s};
                else           shift <= {ser_s, shift[DATA_W-1:1]};
            end else begin
                cnt <= '0;
            end
            // A bad stop bit still delivers the payload; the flag tells the consumer.
            if (in_stop) begin
                rx_valid     <= 1'b1;
                rx_data      <= shift;
                rx_frame_err <= (ser_s != STOP_BIT);
            end
        end
    end

`ifdef SERDES_FRAMED_PARITY_EN
    logic par_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad       <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            if (state == RX_PAR) par_bad <= ser_s ^ (^shift);
            if (in_stop)         rx_parity_err <= par_bad;
        end
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: rtl/serdes_framed.sv
// Full-duplex framed serialiser/deserialiser with TX handshake and internal loopback.
// Define SERDES_FRAMED_PARITY_EN to add an even-parity bit to every frame.
module serdes_framed #(
    parameter int DATA_W      = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              ser_out,
    input  logic              ser_in,
    input  logic              lb_en,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_parity_err
);
    import serdes_pkg::*;

    localparam int            CW   = cnt_w(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    tx_state_e         tx_state, tx_state_nxt;
    logic [DATA_W-1:0] tx_shift;
    logic [CW-1:0]     tx_cnt;
    logic              tx_fire;
    logic              ser_eff;

    assign tx_fire = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_fire) tx_state_nxt = TX_START;
            TX_START: tx_state_nxt = TX_DATA;
`ifdef SERDES_FRAMED_PARITY_EN
            TX_DATA:  if (tx_cnt == LAST) tx_state_nxt = TX_PAR;
`else
            TX_DATA:  if (tx_cnt == LAST) tx_state_nxt = TX_STOP;
`endif
            TX_PAR:   tx_state_nxt = TX_STOP;
            // Accepting during STOP chains frames with no idle gap.
            TX_STOP:  tx_state_nxt = tx_fire ? TX_START : TX_IDLE;
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

`ifdef SERDES_FRAMED_PARITY_EN
    logic tx_par;

    always_ff @(posedge clk) begin
        if (rst)          tx_par <= 1'b0;
        else if (tx_fire) tx_par <= ^tx_data;
    end
`endif

    always_comb begin
        tx_ready = !rst && (tx_state == TX_IDLE || tx_state == TX_STOP);
        ser_out  = IDLE_LVL;
        case (tx_state)
            TX_START: ser_out = START_BIT;
            TX_DATA:  ser_out = MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0];
`ifdef SERDES_FRAMED_PARITY_EN
            TX_PAR:   ser_out = tx_par;
`endif
            TX_STOP:  ser_out = STOP_BIT;
            default:  ser_out = IDLE_LVL;
        endcase
    end

    // The word is captured at accept so tx_data is free to change during the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= '0;
            tx_cnt   <= '0;
        end else begin
            if (tx_fire) begin
                tx_shift <= tx_data;
            end else if (tx_state == TX_DATA) begin
                if (MSB_FIRST) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                else           tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
            end
            tx_cnt <= (tx_state == TX_DATA) ? tx_cnt + CW'(1) : '0;
        end
    end

    assign ser_eff = lb_en ? ser_out : ser_in;

    serdes_rx_deframer #(
        .DATA_W      (DATA_W),
        .MSB_FIRST   (MSB_FIRST),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .ser_line      (ser_eff),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err)
    );

endmodule

// File: tb/tb_serdes_framed.sv
// Randomised bench for serdes_framed: two configurations checked against a frame-level model.
// Honours SERDES_FRAMED_PARITY_EN when the bench and RTL are built with it.
module tb_serdes_framed;

`ifdef SERDES_FRAMED_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int SYNC = 2;

    typedef bit bitq_t[$];
    typedef struct {
        int          t;
        logic [31:0] data;
        logic        ferr;
        logic        perr;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tx_word = '0;
    logic        tx_valid_drv = 1'b0;
    logic        ser_drv = 1'b1;
    logic        lb_en_a = 1'b1;
    logic        use_b = 1'b0;

    logic [7:0]  a_rx_data;
    logic        a_tx_ready, a_ser_out, a_rx_valid, a_ferr, a_perr;
    logic [11:0] b_rx_data;
    logic        b_tx_ready, b_ser_out, b_rx_valid, b_ferr, b_perr;

    logic        obs_ready, obs_ser, obs_valid, obs_ferr, obs_perr;
    logic [31:0] obs_data;

    int          n_checks = 0;
    int          n_pass = 0;
    int          t = 0;
    logic        line_log[$];
    pulse_t      pulses[$];
    logic [31:0] tx_q[$];

    always #5 clk = ~clk;

    serdes_framed u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_word[7:0]),
        .tx_valid      (tx_valid_drv && !use_b),
        .tx_ready      (a_tx_ready),
        .ser_out       (a_ser_out),
        .ser_in        (ser_drv),
        .lb_en         (lb_en_a),
        .rx_data       (a_rx_data),
        .rx_valid      (a_rx_valid),
        .rx_frame_err  (a_ferr),
        .rx_parity_err (a_perr)
    );

    serdes_framed #(.DATA_W(12), .MSB_FIRST(1'b0), .SYNC_STAGES(SYNC)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_word[11:0]),
        .tx_valid      (tx_valid_drv && use_b),
        .tx_ready      (b_tx_ready),
        .ser_out       (b_ser_out),
        .ser_in        (ser_drv),
        .lb_en         (1'b1),
        .rx_data       (b_rx_data),
        .rx_valid      (b_rx_valid),
        .rx_frame_err  (b_ferr),
        .rx_parity_err (b_perr)
    );

    always_comb begin
        if (use_b) begin
            obs_ready = b_tx_ready; obs_ser = b_ser_out; obs_valid = b_rx_valid;
            obs_data  = 32'(b_rx_data); obs_ferr = b_ferr; obs_perr = b_perr;
        end else begin
            obs_ready = a_tx_ready; obs_ser = a_ser_out; obs_valid = a_rx_valid;
            obs_data  = 32'(a_rx_data); obs_ferr = a_ferr; obs_perr = a_perr;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to the next falling edge and log what the selected DUT shows.
    task automatic step();
        pulse_t p;
        @(negedge clk);
        t++;
        line_log.push_back(obs_ser);
        if (obs_valid) begin
            p.t = t; p.data = obs_data; p.ferr = obs_ferr; p.perr = obs_perr;
            pulses.push_back(p);
        end
    endtask

    function automatic int cur_w();
        return use_b ? 12 : 8;
    endfunction

    function automatic int frame_len(input int w);
        return w + 2 + PAR_BITS;
    endfunction

    // Line image of one frame: start, payload in wire order, optional even parity, stop.
    function automatic bitq_t frame_bits(input logic [31:0] p, input int w, input bit msb);
        bitq_t q;
        bit    par = 1'b0;
        q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            int idx = msb ? (w - 1 - i) : i;
            q.push_back(p[idx]);
            par ^= p[idx];
        end
        if (PAR_BITS == 1) q.push_back(par);
        q.push_back(1'b1);
        return q;
    endfunction

    // Send tx_q[0..n-1] with tx_valid held, in loopback, and check line and RX.
    task automatic run_lb(input int n);
        int    acc[$];
        int    sent = 0;
        bit    accepting;
        int    w   = cur_w();
        int    fl  = frame_len(w);
        int    lat = fl + SYNC;
        bitq_t exp_bits;
        logic [63:0] got_line = '0;
        logic [63:0] exp_line = '0;

        pulses.delete();
        tx_word = tx_q[0];
        tx_valid_drv = 1'b1;
        check("ready_idle", 64'(obs_ready), 64'(1));
        for (int c = 0; c < n * fl + lat + 4; c++) begin
            accepting = tx_valid_drv && obs_ready;
            if (accepting) acc.push_back(t + 1);
            step();
            if (accepting) begin
                sent++;
                if (sent < n) tx_word = tx_q[sent];
                else begin tx_valid_drv = 1'b0; tx_word = $urandom; end
            end
        end
        tx_valid_drv = 1'b0;
        check("accepts", 64'(sent), 64'(n));
        if (acc.size() == 0) return;
        for (int j = 1; j < acc.size(); j++) check("b2b_gap", 64'(acc[j] - acc[j-1]), 64'(fl));
        for (int j = 0; j < n; j++) begin
            bitq_t fb = frame_bits(tx_q[j], w, !use_b);
            foreach (fb[k]) exp_bits.push_back(fb[k]);
        end
        foreach (exp_bits[k]) begin
            exp_line[k] = exp_bits[k];
            got_line[k] = line_log[acc[0] + k];
        end
        check("line", got_line, exp_line);
        check("n_pulses", 64'(pulses.size()), 64'(n));
        for (int j = 0; j < n && j < pulses.size(); j++) begin
            check("rx_time", 64'(pulses[j].t - acc[0]), 64'(j * fl + lat));
            check("rx_data", 64'(pulses[j].data), 64'(tx_q[j]));
            check("rx_ferr", 64'(pulses[j].ferr), 64'(0));
            check("rx_perr", 64'(pulses[j].perr), 64'(0));
        end
    endtask

    // Drive one frame on ser_in of DUT A, optionally corrupting stop or parity.
    task automatic ext_frame(input logic [31:0] payload, input bit bad_stop, input bit bad_par);
        bitq_t b   = frame_bits(payload, 8, 1'b1);
        int    fl  = b.size();
        int    lat = fl + SYNC;
        int    t0;
        if (bad_stop) b[fl-1] = 1'b0;
        if (bad_par)  b[fl-2] = ~b[fl-2];
        pulses.delete();
        t0 = t;
        for (int k = 0; k < fl; k++) begin
            ser_drv = b[k];
            step();
        end
        ser_drv = 1'b1;
        repeat (lat - fl + 3) step();
        check("ext_pulses", 64'(pulses.size()), 64'(1));
        if (pulses.size() > 0) begin
            check("ext_time", 64'(pulses[0].t - t0), 64'(lat));
            check("ext_data", 64'(pulses[0].data), 64'(payload));
            check("ext_ferr", 64'(pulses[0].ferr), 64'(bad_stop));
            check("ext_perr", 64'(pulses[0].perr), 64'(bad_par));
        end
    endtask

    initial begin
        int fl_a;
        int lat_a;
        int t0;
        line_log.push_back(1'b1);
        fl_a  = frame_len(8);
        lat_a = fl_a + SYNC;

        // Reset held for three edges, then released.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ser", 64'(a_ser_out), 64'(1));
            check("rst_valid", 64'(a_rx_valid), 64'(0));
            check("rst_ready", 64'(a_tx_ready), 64'(0));
        end
        rst = 1'b0;
        pulses.delete();
        step();
        check("post_rst_ready", 64'(a_tx_ready), 64'(1));
        check("post_rst_ser", 64'(a_ser_out), 64'(1));
        check("post_rst_data", 64'(a_rx_data), 64'(0));
        repeat (lat_a) step();
        check("no_false_start", 64'(pulses.size()), 64'(0));

        // Directed loopback frames, then back-to-back pair.
        tx_q = '{32'h0000_00A5};
        run_lb(1);
        tx_q = '{32'h0000_003C, 32'h0000_00C3};
        run_lb(2);

        // External line: forced-low stop bit, then a clean frame.
        lb_en_a = 1'b0;
        ext_frame(32'h81, 1'b1, 1'b0);
        ext_frame(32'h55, 1'b0, 1'b0);
`ifdef SERDES_FRAMED_PARITY_EN
        ext_frame(32'h07, 1'b0, 1'b1);
`endif

        // Line held low: one frame error every frame length, no lockup.
        pulses.delete();
        t0 = t;
        ser_drv = 1'b0;
        repeat (3 * fl_a) step();
        ser_drv = 1'b1;
        repeat (lat_a + 3) step();
        check("low_pulses", 64'(pulses.size()), 64'(3));
        foreach (pulses[j]) begin
            check("low_time", 64'(pulses[j].t - t0), 64'(lat_a + j * fl_a));
            check("low_ferr", 64'(pulses[j].ferr), 64'(1));
            check("low_data", 64'(pulses[j].data), 64'(0));
        end
        lb_en_a = 1'b1;

        // Wide LSB-first configuration.
        use_b = 1'b1;
        tx_q = '{32'h0000_0123};
        run_lb(1);
`ifdef SERDES_FRAMED_PARITY_EN
        use_b = 1'b0;
        tx_q = '{32'h0000_0007};
        run_lb(1);
`endif

        // Random loopback traffic on both configurations.
        for (int r = 0; r < 8; r++) begin
            int n;
            use_b = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 2);
            tx_q.delete();
            for (int j = 0; j < n; j++) tx_q.push_back($urandom & ((32'd1 << cur_w()) - 1));
            run_lb(n);
        end

        // Random external frames with random corruption.
        use_b = 1'b0;
        lb_en_a = 1'b0;
        for (int r = 0; r < 5; r++) begin
            bit bs = 1'($urandom_range(0, 1));
            bit bp = (PAR_BITS == 1) && ($urandom_range(0, 1) == 1);
            ext_frame($urandom & 32'hFF, bs, bp);
        end
        lb_en_a = 1'b1;

        // Reset in the middle of a loopback frame aborts it.
        tx_word = $urandom & 32'hFF;
        tx_valid_drv = 1'b1;
        step();
        tx_valid_drv = 1'b0;
        repeat (5) step();
        pulses.delete();
        rst = 1'b1;
        step();
        check("mid_rst_ser", 64'(a_ser_out), 64'(1));
        check("mid_rst_valid", 64'(a_rx_valid), 64'(0));
        check("mid_rst_ready", 64'(a_tx_ready), 64'(0));
        rst = 1'b0;
        step();
        check("mid_rst_ser_after", 64'(a_ser_out), 64'(1));
        repeat (lat_a + fl_a) step();
        check("mid_rst_abort", 64'(pulses.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
